// File: rtl/nice_fm_streamer_if.sv
// Command/response handshake bundle between the NICE command path and the
// feature-map streamer. Signal names keep the streamer-side direction prefix.
interface nice_fm_streamer_if #(
  parameter int AW = 16
);
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [AW-1:0] i_cmd_base;
  logic          i_cmd_reload;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [4:0]    o_rsp_data;
  logic          o_busy;

  modport slave (
    input  i_cmd_valid, i_cmd_base, i_cmd_reload, i_rsp_ready,
    output o_cmd_ready, o_rsp_valid, o_rsp_data, o_busy
  );

  modport master (
    output i_cmd_valid, i_cmd_base, i_cmd_reload, i_rsp_ready,
    input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_busy
  );
endinterface

// File: rtl/nice_fm_streamer.sv
// Host-side driver for the accelerator in non-camera builds: optionally kicks
// the weight DMA, streams a ROWS x COLS 8-bit image out of a 16-bit word
// memory one packed row at a time, then returns the classification result.
module nice_fm_streamer #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int ROWS    = 26,
  parameter int COLS    = 26,
  parameter int ROW_GAP = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  nice_fm_streamer_if.slave nice,
  output logic [AW-1:0]     o_img_addr,
  output logic              o_img_cs,
  input  logic [DW-1:0]     i_img_data,
  output logic              o_start,
  input  logic              i_data_ready,
  output logic [8*COLS-1:0] o_parallel_data,
  output logic              o_fm_data_valid,
  input  logic [4:0]        i_result_data,
  input  logic              i_result_data_valid
);

  localparam int WORDS = COLS / 2;
  localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int GW    = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;

  localparam logic [KW-1:0] WORD_LAST  = KW'(WORDS - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(ROW_GAP - 1);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(WORDS);

  typedef enum logic [3:0] {
    IDLE,
    START,
    LOAD_W,
    FETCH,
    CAPT,
    EMIT,
    GAP,
    WAIT_RES,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   wordCnt_q;
  logic [RW-1:0]   rowCnt_q;
  logic [GW-1:0]   gapCnt_q;
  logic [AW-1:0]   rowBase_q;
  logic            weightsLoaded_q;
  logic            readyPrev_q;
  logic            rdValid_q;
  logic [KW-1:0]   rdIdx_q;
  logic [8*COLS-1:0] pixels_q;
  logic [4:0]      rspData_q;
  logic            cmdReady_q;

  logic cmdAccept;
  logic readyRise;
  logic wordLast;
  logic rowLast;
  logic gapLast;

  assign readyRise = i_data_ready & ~readyPrev_q;
  assign wordLast  = (wordCnt_q == WORD_LAST);
  assign rowLast   = (rowCnt_q == ROW_LAST);
  assign gapLast   = (gapCnt_q == GAP_LAST);

  assign o_start         = (state_q == START);
  assign o_img_cs        = (state_q == FETCH);
  assign o_img_addr      = o_img_cs ? (rowBase_q + AW'(wordCnt_q)) : '0;
  assign o_fm_data_valid = (state_q == EMIT);
  assign o_parallel_data = pixels_q;

  assign nice.o_cmd_ready = cmdReady_q;
  assign nice.o_busy      = (state_q != IDLE);
  assign nice.o_rsp_valid = (state_q == RESP);
  assign nice.o_rsp_data  = rspData_q;

  // Next-state logic: walks the command through weight load, row streaming and response
  always_comb begin
    state_d   = state_q;
    cmdAccept = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (nice.i_cmd_valid && cmdReady_q) begin
          cmdAccept = 1'b1;
          state_d   = (nice.i_cmd_reload || !weightsLoaded_q) ? START : FETCH;
        end
      end
      START:  state_d = LOAD_W;
      LOAD_W: if (readyRise) state_d = FETCH;
      FETCH:  if (wordLast) state_d = CAPT;
      CAPT:   state_d = EMIT;
      EMIT: begin
        if (rowLast)           state_d = WAIT_RES;
        else if (ROW_GAP == 0) state_d = FETCH;
        else                   state_d = GAP;
      end
      GAP:      if (gapLast) state_d = FETCH;
      WAIT_RES: if (i_result_data_valid) state_d = RESP;
      RESP:     if (nice.i_rsp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register; command ready is registered so it stays low while reset is applied
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cmdReady_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmdReady_q <= (state_d == IDLE);
    end
  end

  // Word, row and gap counters plus the running word address of the current row
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wordCnt_q <= '0;
      rowCnt_q  <= '0;
      gapCnt_q  <= '0;
      rowBase_q <= '0;
    end else begin
      wordCnt_q <= (state_q == FETCH) ? wordCnt_q + 1'b1 : '0;
      gapCnt_q  <= (state_q == GAP) ? gapCnt_q + 1'b1 : '0;
      if (cmdAccept) begin
        rowCnt_q  <= '0;
        rowBase_q <= nice.i_cmd_base;
      end else if (state_q == EMIT && !rowLast) begin
        rowCnt_q  <= rowCnt_q + 1'b1;
        rowBase_q <= rowBase_q + ROW_STRIDE;
      end
    end
  end

  // DMA-done edge detector, pre-set high outside LOAD_W so a stale high level is not an edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      readyPrev_q     <= 1'b0;
      weightsLoaded_q <= 1'b0;
    end else begin
      readyPrev_q <= (state_q == LOAD_W) ? i_data_ready : 1'b1;
      if (state_q == LOAD_W && readyRise) weightsLoaded_q <= 1'b1;
    end
  end

  // Track which word the synchronous memory returns this cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdValid_q <= 1'b0;
      rdIdx_q   <= '0;
    end else begin
      rdValid_q <= (state_q == FETCH);
      rdIdx_q   <= wordCnt_q;
    end
  end

  // Pack returned words into the row bus, pixel 0 in the MSBs, low byte first
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pixels_q <= '0;
    end else begin
      for (int w = 0; w < WORDS; w++) begin
        if (rdValid_q && rdIdx_q == KW'(w)) begin
          pixels_q[8*(COLS-2*w)-1 -: 16] <= {i_img_data[7:0], i_img_data[15:8]};
        end
      end
    end
  end

  // Result capture, only honoured while waiting for it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rspData_q <= '0;
    end else if (state_q == WAIT_RES && i_result_data_valid) begin
      rspData_q <= i_result_data;
    end
  end

endmodule

// File: tb/tb_nice_fm_streamer.sv
// Directed bench for nice_fm_streamer: one instance with default row gap and
// one with zero row gap, each with a small image memory model and a monitor.
module tb_nice_fm_streamer;

  localparam int ROWS = 26;
  localparam int COLS = 26;
  localparam int W    = 8 * COLS;

  logic clk = 1'b0;
  logic rstN;
  int   cyc = 0;
  int   testCount = 0;
  int   failCount = 0;

  logic        cmdValid  [2];
  logic        cmdReload [2];
  logic [15:0] cmdBase   [2];
  logic        rspReady  [2];
  logic        dataReady [2];
  logic        resValid  [2];
  logic [4:0]  resData   [2];

  logic        cmdReady  [2];
  logic        busy      [2];
  logic        rspValid  [2];
  logic [4:0]  rspData   [2];
  logic        startP    [2];
  logic        imgCs     [2];
  logic [15:0] imgAddr   [2];
  logic [15:0] imgData   [2];
  logic        fmValid   [2];
  logic [W-1:0] parData  [2];

  int          acceptCyc  [2] = '{0, 0};
  int          rowCnt     [2] = '{0, 0};
  int          kCnt       [2] = '{0, 0};
  int          startCnt   [2] = '{0, 0};
  int          startOff   [2] = '{-1, -1};
  int          lastValid  [2] = '{0, 0};
  int          expLatency [2] = '{-1, -1};
  logic [15:0] monBase    [2] = '{16'h0, 16'h0};
  logic [15:0] prevAddr   [2] = '{16'h0, 16'h0};
  logic        sawWrap    [2] = '{1'b0, 1'b0};
  logic [4:0]  lastRsp    [2] = '{5'd0, 5'd0};

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [W-1:0] expRow(input logic [15:0] base, input int r);
    logic [W-1:0] v;
    int p;
    v = '0;
    for (int j = 0; j < COLS; j++) begin
      p = 2 * int'(base) + 2 * (COLS / 2) * r + j;
      v[8*(COLS-j)-1 -: 8] = p[7:0];
    end
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gInst
    localparam int RG      = (g == 0) ? 2 : 0;
    localparam int SPACING = COLS / 2 + 2 + RG;

    nice_fm_streamer_if #(.AW(16)) nif ();

    assign nif.i_cmd_valid  = cmdValid[g];
    assign nif.i_cmd_base   = cmdBase[g];
    assign nif.i_cmd_reload = cmdReload[g];
    assign nif.i_rsp_ready  = rspReady[g];
    assign cmdReady[g]      = nif.o_cmd_ready;
    assign busy[g]          = nif.o_busy;
    assign rspValid[g]      = nif.o_rsp_valid;
    assign rspData[g]       = nif.o_rsp_data;

    nice_fm_streamer #(
      .DW(16), .AW(16), .ROWS(ROWS), .COLS(COLS), .ROW_GAP(RG)
    ) dut (
      .i_clk               (clk),
      .i_rst_n             (rstN),
      .nice                (nif),
      .o_img_addr          (imgAddr[g]),
      .o_img_cs            (imgCs[g]),
      .i_img_data          (imgData[g]),
      .o_start             (startP[g]),
      .i_data_ready        (dataReady[g]),
      .o_parallel_data     (parData[g]),
      .o_fm_data_valid     (fmValid[g]),
      .i_result_data       (resData[g]),
      .i_result_data_valid (resValid[g])
    );

    // Image memory: word at address a holds bytes {2a+1, 2a}
    always @(posedge clk) begin
      if (imgCs[g]) imgData[g] <= {imgAddr[g][6:0], 1'b1, imgAddr[g][6:0], 1'b0};
    end

    // Monitor: tracks accepts, start pulses, fetch addresses and emitted rows
    always @(negedge clk) begin : monitor
      logic [15:0] ea;
      if (rstN && cmdValid[g] && cmdReady[g]) begin
        acceptCyc[g] = cyc;
        rowCnt[g]    = 0;
        kCnt[g]      = 0;
        monBase[g]   = cmdBase[g];
        startCnt[g]  = 0;
        startOff[g]  = -1;
        sawWrap[g]   = 1'b0;
        prevAddr[g]  = cmdBase[g];
      end
      if (startP[g]) begin
        startCnt[g]++;
        startOff[g] = cyc - acceptCyc[g];
      end
      if (imgCs[g]) begin
        ea = monBase[g] + 16'((COLS / 2) * rowCnt[g] + kCnt[g]);
        checkOutput("img_addr", W'(imgAddr[g]), W'(ea));
        if (prevAddr[g] == 16'hFFFF && imgAddr[g] == 16'h0000) sawWrap[g] = 1'b1;
        prevAddr[g] = imgAddr[g];
        kCnt[g]++;
      end
      if (fmValid[g]) begin
        checkOutput("row_words", W'(kCnt[g]), W'(COLS / 2));
        checkOutput("row_data", parData[g], expRow(monBase[g], rowCnt[g]));
        if (rowCnt[g] == 0 && expLatency[g] >= 0)
          checkOutput("first_latency", W'(cyc - acceptCyc[g]), W'(expLatency[g]));
        if (rowCnt[g] > 0)
          checkOutput("valid_spacing", W'(cyc - lastValid[g]), W'(SPACING));
        lastValid[g] = cyc;
        rowCnt[g]++;
        kCnt[g] = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int u, input logic [15:0] base, input logic reload,
                               input int expLat);
    expLatency[u] = expLat;
    cmdBase[u]    = base;
    cmdReload[u]  = reload;
    cmdValid[u]   = 1'b1;
    for (int t = 0; t < 20 && !cmdReady[u]; t++) tick();
    checkOutput("cmd_ready", W'(cmdReady[u]), W'(1));
    tick();
    cmdValid[u]  = 1'b0;
    cmdReload[u] = 1'b0;
  endtask

  task automatic loadWeights(input int u, input logic stale);
    if (!stale) dataReady[u] = 1'b0;
    checkOutput("start_high", W'(startP[u]), W'(1));
    tick();
    if (stale) begin
      for (int t = 0; t < 6; t++) begin
        tick();
        checkOutput("stale_hold", W'(imgCs[u]), W'(0));
      end
      dataReady[u] = 1'b0;
      tick();
    end else begin
      tick();
    end
    dataReady[u] = 1'b1;
  endtask

  task automatic finishCommand(input int u, input int stray, input logic [4:0] result,
                               input int hold, input int expStarts);
    if (stray >= 0) begin
      for (int t = 0; t < 200 && rowCnt[u] < 5; t++) tick();
      resData[u]  = 5'(stray);
      resValid[u] = 1'b1;
      tick();
      resValid[u] = 1'b0;
      checkOutput("stray_data", W'(rspData[u]), W'(lastRsp[u]));
      checkOutput("stray_valid", W'(rspValid[u]), W'(0));
    end
    for (int t = 0; t < 600 && rowCnt[u] < ROWS; t++) tick();
    checkOutput("row_count", W'(rowCnt[u]), W'(ROWS));
    checkOutput("rsp_idle", W'(rspValid[u]), W'(0));
    resData[u]  = result;
    resValid[u] = 1'b1;
    rspReady[u] = 1'b0;
    tick();
    resValid[u] = 1'b0;
    checkOutput("rsp_valid", W'(rspValid[u]), W'(1));
    checkOutput("rsp_data", W'(rspData[u]), W'(result));
    for (int h = 0; h < hold; h++) begin
      tick();
      checkOutput("rsp_hold_valid", W'(rspValid[u]), W'(1));
      checkOutput("rsp_hold_data", W'(rspData[u]), W'(result));
    end
    rspReady[u] = 1'b1;
    tick();
    rspReady[u] = 1'b0;
    checkOutput("rsp_drop", W'(rspValid[u]), W'(0));
    checkOutput("ready_back", W'(cmdReady[u]), W'(1));
    checkOutput("busy_clear", W'(busy[u]), W'(0));
    lastRsp[u] = result;
    checkOutput("start_count", W'(startCnt[u]), W'(expStarts));
    if (expStarts > 0) checkOutput("start_offset", W'(startOff[u]), W'(1));
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      cmdValid[u]  = 1'b0;
      cmdReload[u] = 1'b0;
      cmdBase[u]   = 16'h0;
      rspReady[u]  = 1'b0;
      dataReady[u] = 1'b0;
      resValid[u]  = 1'b0;
      resData[u]   = 5'd0;
    end
    rstN = 1'b0;
    repeat (3) tick();
    checkOutput("por_cmd_ready", W'(cmdReady[0]), W'(0));
    rstN = 1'b1;
    repeat (2) tick();

    applyStimulus(0, 16'h0100, 1'b0, -1);
    loadWeights(0, 1'b0);
    finishCommand(0, -1, 5'd21, 0, 1);

    applyStimulus(0, 16'h0200, 1'b0, 15);
    finishCommand(0, 3, 5'd7, 5, 0);

    applyStimulus(0, 16'h0040, 1'b1, -1);
    loadWeights(0, 1'b1);
    finishCommand(0, -1, 5'd9, 0, 1);

    applyStimulus(0, 16'h0300, 1'b0, 15);
    repeat (5) tick();
    checkOutput("midfetch_cs", W'(imgCs[0]), W'(1));
    rstN = 1'b0;
    #1;
    checkOutput("rst_busy", W'(busy[0]), W'(0));
    checkOutput("rst_cmd_ready", W'(cmdReady[0]), W'(0));
    checkOutput("rst_cs", W'(imgCs[0]), W'(0));
    checkOutput("rst_addr", W'(imgAddr[0]), W'(0));
    checkOutput("rst_start", W'(startP[0]), W'(0));
    checkOutput("rst_fm_valid", W'(fmValid[0]), W'(0));
    checkOutput("rst_par_data", parData[0], W'(0));
    checkOutput("rst_rsp_valid", W'(rspValid[0]), W'(0));
    checkOutput("rst_rsp_data", W'(rspData[0]), W'(0));
    tick();
    rstN = 1'b1;
    checkOutput("ready_at_release", W'(cmdReady[0]), W'(0));
    tick();
    checkOutput("ready_after_release", W'(cmdReady[0]), W'(1));
    lastRsp[0] = 5'd0;

    applyStimulus(0, 16'h0100, 1'b0, -1);
    loadWeights(0, 1'b0);
    finishCommand(0, -1, 5'd12, 0, 1);

    applyStimulus(1, 16'hFFF8, 1'b1, -1);
    loadWeights(1, 1'b0);
    finishCommand(1, -1, 5'd2, 0, 1);
    checkOutput("addr_wrap", W'(sawWrap[1]), W'(1));

    applyStimulus(1, 16'h0010, 1'b0, 15);
    finishCommand(1, -1, 5'd30, 2, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
